// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit feeding the register file write port.
// One operation is accepted in IDLE. It runs DataBitWidth shift-add or
// restoring shift-subtract steps, then issues a single-cycle register write.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
//
// Handshake: a request is taken when start=1 and the unit is in IDLE. busy is
// high from the cycle after acceptance through the DONE cycle. done pulses
// for exactly one cycle when rd/rd_data_out are valid. rd_write_enable pulses
// in that same cycle unless rd is 0. There is no backpressure from the
// register file.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             operation request (sampled in IDLE only)
//   funct3            RV32M operation select
//   rs1_data/rs2_data operand A / operand B
//   rd_in             destination register index
//   busy, done        status
//   rd, rd_write_enable, rd_data_out   register file write port
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int DataBitWidth    = 32,
   parameter int AddressBitWidth = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [2:0]                 funct3,
   input  logic [DataBitWidth-1:0]    rs1_data,
   input  logic [DataBitWidth-1:0]    rs2_data,
   input  logic [AddressBitWidth-1:0] rd_in,
   output logic                       busy,
   output logic                       done,
   output logic [AddressBitWidth-1:0] rd,
   output logic                       rd_write_enable,
   output logic [DataBitWidth-1:0]    rd_data_out,
   output logic [1:0]                 dbg_state
);

   localparam int W  = DataBitWidth;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LastStep = CW'(W - 1);
   localparam logic [W-1:0]  MinNeg   = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                     state_q;
   logic                       busy_q, done_q, we_q;
   logic [AddressBitWidth-1:0] rd_out_q, rd_q;
   logic [W-1:0]               data_q;
   logic [2:0]                 op_q;
   logic [CW-1:0]              cnt_q;
   logic [W-1:0]               opnd_q;   // multiplicand (mul) or divisor (div)
   logic [W-1:0]               hi_q;     // product high half / partial remainder
   logic [W-1:0]               lo_q;     // multiplier bits / dividend-quotient
   logic                       neg_q;    // negate product or quotient
   logic                       neg_rem_q;

   // ---------------- request decode (used only on acceptance) -------------
   logic         is_div_in, a_signed, b_signed, a_neg, b_neg;
   logic         div_zero, div_ovf, special;
   logic [W-1:0] a_mag, b_mag, special_res;

   always_comb begin
      is_div_in = funct3[2];
      // MUL, MULH, MULHSU, DIV, REM treat A as signed.
      a_signed  = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
      b_signed  = a_signed && (funct3 != 3'b010);
      a_neg     = a_signed && rs1_data[W-1];
      b_neg     = b_signed && rs2_data[W-1];
      a_mag     = a_neg ? (~rs1_data + 1'b1) : rs1_data;
      b_mag     = b_neg ? (~rs2_data + 1'b1) : rs2_data;
      div_zero  = is_div_in && (rs2_data == '0);
      div_ovf   = is_div_in && !funct3[0] && (rs1_data == MinNeg) && (rs2_data == '1);
      special   = div_zero || div_ovf;
      if (div_zero) special_res = funct3[1] ? rs1_data : '1;
      else          special_res = funct3[1] ? '0 : rs1_data;
   end

   // ---------------- one iteration step ----------------------------------
   logic [W:0]     mul_sum, div_shift, div_diff;
   logic [W-1:0]   hi_d, lo_d, quo_s, rem_s;
   logic [2*W-1:0] prod_d, prod_s;
   logic [W-1:0]   result_d;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[W-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (op_q[2]) begin
         // Restoring divide: the remainder stays below the divisor, so the
         // top bit of the (W+1)-bit difference is a clean borrow flag.
         if (!div_diff[W]) begin
            hi_d = div_diff[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b1};
         end else begin
            hi_d = div_shift[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
         end
      end else begin
         // Shift-add multiply: {carry, hi, lo} shifted right by one.
         hi_d = mul_sum[W:1];
         lo_d = {mul_sum[0], lo_q[W-1:1]};
      end

      prod_d = {hi_d, lo_d};
      prod_s = neg_q ? (~prod_d + 1'b1) : prod_d;
      quo_s  = neg_q ? (~lo_d + 1'b1) : lo_d;
      rem_s  = neg_rem_q ? (~hi_d + 1'b1) : hi_d;

      case (op_q)
         3'b000:                 result_d = prod_s[W-1:0];
         3'b001, 3'b010, 3'b011: result_d = prod_s[2*W-1:W];
         3'b100, 3'b101:         result_d = quo_s;
         default:                result_d = rem_s;
      endcase
   end

   // ---------------- FSM with registered outputs --------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         rd_out_q  <= '0;
         data_q    <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         we_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q    <= 1'b1;
                  op_q      <= funct3;
                  rd_q      <= rd_in;
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  cnt_q     <= '0;
                  hi_q      <= '0;
                  opnd_q    <= is_div_in ? b_mag : a_mag;
                  lo_q      <= is_div_in ? a_mag : b_mag;
                  if (special) begin
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     we_q     <= (rd_in != '0);
                     rd_out_q <= rd_in;
                     data_q   <= special_res;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastStep) begin
                  state_q  <= ST_DONE;
                  done_q   <= 1'b1;
                  we_q     <= (rd_q != '0);
                  rd_out_q <= rd_q;
                  data_q   <= result_d;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign rd              = rd_out_q;
   assign rd_write_enable = we_q;
   assign rd_data_out     = data_q;
   assign dbg_state       = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits directly upstream of the register file write port. It accepts one operation with its two source-operand values (already read from the register file) and the destination register index. It computes the result over multiple cycles, then drives a single-cycle write (`rd`, `rd_write_enable`, `rd_data_out`) straight into the register file. The core stalls on `busy`.

## Interface

Parameters:
- `DataBitWidth`, 32, operand/result width; iteration count equals this value
- `AddressBitWidth`, 5, register index width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `start`  in  1  operation request; sampled only in IDLE
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_data`  in  DataBitWidth  operand A (dividend / multiplicand)
- `rs2_data`  in  DataBitWidth  operand B (divisor / multiplier)
- `rd_in`  in  AddressBitWidth  destination index, latched with operands
- `busy`  out  1  high while an accepted operation is not yet retired
- `done`  out  1  one-cycle pulse when the result is presented
- `rd`  out  AddressBitWidth  destination index to register file
- `rd_write_enable`  out  1  register file write strobe
- `rd_data_out`  out  DataBitWidth  result to register file

## Operation

- States: IDLE, RUN, DONE.
- IDLE with `start`=1: latch `funct3`, `rd_in`, and operand magnitudes plus sign flags. Then:
  - Special case → DONE.
  - Otherwise → RUN with step counter = 0.
- RUN: one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle. After step DataBitWidth−1 → DONE.
- DONE: present result. Always → IDLE next cycle.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Arithmetic on magnitudes, with sign correction at the end:
  - Product of width 2×DataBitWidth is negated if sign(A) xor sign(B).
  - Quotient is negated if sign(A) xor sign(B).
  - Remainder is negated if sign(A).
- Result selection: MUL returns the low DataBitWidth bits of the product; MULH/MULHSU/MULHU return the high bits.
- Special cases (no RUN phase):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return `rs1_data`.
  - Signed overflow (A = most-negative, B = −1): DIV returns A; REM returns 0.
- `rd`=0: `rd_write_enable` stays 0; `done` still pulses.
- `start` while not in IDLE is ignored; there is no queueing.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `rd_write_enable`=0, `rd`=0, `rd_data_out`=0.
- `start` accepted at the edge ending cycle T:
  - `busy`=1 from T+1.
  - Normal ops: RUN occupies T+1..T+DataBitWidth; DONE at T+DataBitWidth+1 (33 cycles for width 32).
  - Special cases: DONE at T+1.
- DONE cycle: `done`=1, `rd_write_enable`=1 (if `rd`≠0), `rd_data_out`/`rd` valid, `busy`=1.
- Next cycle: `busy`=0, `done`=0, `rd_write_enable`=0. A new `start` is accepted in this first IDLE cycle, giving back-to-back spacing of DataBitWidth+2 cycles.
- `rd_data_out` and `rd` hold their last values in IDLE. Consumers qualify them with `rd_write_enable`.
- `rst` asserted in any state: next state IDLE and all outputs take reset values. An in-flight operation is discarded with no write.
- Input operands may change after acceptance without affecting the result.

## Test plan

- MUL, A=7, B=0xFFFFFFFD (−3), `rd_in`=5, start at T: `rd_write_enable`=1, `rd`=5, `rd_data_out`=0xFFFFFFEB exactly at T+33; `busy` high T+1..T+33.
- High-product ops:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Special cases, each with result at T+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- `rd_in`=0 with MUL 3×4: `done` pulses at T+33, `rd_write_enable` stays 0. A second `start` pulsed during RUN is ignored. A `start` at T+34 is accepted.
- `rst` asserted at T+10 of a DIV: all outputs zero at T+11, no write ever issued. A fresh REMU 10/3 afterwards returns 1.
